// File: rtl/updown_cmd_gen_pkg.sv
// Shared types and constants for the up/down counter command generator.
package updown_cmd_pkg;

  localparam int unsigned DEF_WIDTH = 4;

  // Half of the counter range; the tie point when choosing the shorter way round.
  function automatic int unsigned half_of(input int unsigned width);
    return 2 ** (width - 1);
  endfunction

  localparam int unsigned HALF = half_of(DEF_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    CMD,
    WAIT,
    DONE,
    ERR
  } state_t;

  typedef enum logic {
    DIR_UP,
    DIR_DOWN
  } dir_t;

endpackage

// File: rtl/updown_cmd_gen_if.sv
// Command/feedback bundle between the generator and its environment.
interface updown_cmd_gen_if
  import updown_cmd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] count;
  logic             up;
  logic             down;
  logic             busy;
  logic             done;
  logic             err;

  // Generator side: takes requests and counter feedback, drives commands and status.
  modport master (
    input  start, abort, target, count,
    output up, down, busy, done, err
  );

  // Requester/counter side.
  modport slave (
    output start, abort, target, count,
    input  up, down, busy, done, err
  );

endinterface

// File: rtl/updown_cmd_gen_dir_sel.sv
// Direction selector: picks up or down from latched target and live count.
// Build option: SHORTEST_PATH_EN selects the wrap-aware shortest direction.
module updown_dir_sel
  import updown_cmd_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] i_tgt,
  input  logic [WIDTH-1:0] i_count,
  output dir_t             o_dir
);

`ifdef SHORTEST_PATH_EN
  localparam logic [WIDTH-1:0] L_HALF = WIDTH'(half_of(WIDTH));

  logic [WIDTH-1:0] w_dist;

  // Forward distance modulo 2**WIDTH; a tie at exactly half goes up.
  assign w_dist = i_tgt - i_count;
  assign o_dir  = (w_dist <= L_HALF) ? DIR_UP : DIR_DOWN;
`else
  // Plain magnitude compare; never moves through the wrap point.
  assign o_dir = (i_tgt > i_count) ? DIR_UP : DIR_DOWN;
`endif

endmodule

// File: rtl/updown_cmd_gen.sv
// Up/down counter command generator: steps an external counter towards a
// latched target with one-cycle up/down pulses, using its count as feedback.
// Build option: SHORTEST_PATH_EN (see updown_dir_sel) allows wrap-around moves.
module updown_cmd_gen
  import updown_cmd_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned STEP_GAP  = 1,
  parameter int unsigned MAX_STEPS = 2 ** WIDTH
) (
  input  logic             clk,
  input  logic             rstn,
  updown_cmd_gen_if.master bus
);

  localparam int unsigned STEPS_W = $clog2(MAX_STEPS + 1);
  localparam int unsigned GAP_W   = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_tgt;
  logic [STEPS_W-1:0] r_steps;
  logic [GAP_W-1:0]   r_gap;
  logic               r_up;
  logic               r_down;
  logic               r_busy;
  logic               r_done;
  logic               r_err;
  dir_t               w_dir;
  logic               w_at_max;
  logic               w_gap_end;
  logic               w_hit;

  updown_dir_sel #(.WIDTH(WIDTH)) u_dir_sel (
    .i_tgt   (r_tgt),
    .i_count (bus.count),
    .o_dir   (w_dir)
  );

  assign w_hit     = (bus.count == r_tgt);
  assign w_at_max  = (r_steps == STEPS_W'(MAX_STEPS));
  assign w_gap_end = (r_gap == GAP_W'(STEP_GAP - 1));

  // Next-state decode; abort overrides every transition.
  // NOTE: w_next is assigned a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (bus.start) w_next = CHECK;
      CHECK:   if (w_hit)         w_next = DONE;
               else if (w_at_max) w_next = ERR;
               else               w_next = CMD;
      CMD:     w_next = WAIT;
      WAIT:    if (w_gap_end) w_next = CHECK;
      DONE:    w_next = IDLE;
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (bus.abort) w_next = IDLE;
  end

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Registered outputs decoded from the next state, so they change on the same edge as the state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_up   <= (w_next == CMD) && (w_dir == DIR_UP);
      r_down <= (w_next == CMD) && (w_dir == DIR_DOWN);
      r_busy <= (w_next inside {CHECK, CMD, WAIT});
      r_done <= (w_next == DONE);
      r_err  <= (w_next == ERR);
    end
  end

  // Move bookkeeping: latched target, saturating pulse count, post-pulse wait timer.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tgt   <= '0;
      r_steps <= '0;
      r_gap   <= '0;
    end else begin
      if (r_state == IDLE && w_next == CHECK) begin
        r_tgt   <= bus.target;
        r_steps <= '0;
      end
      if (r_state == CMD && !w_at_max) r_steps <= r_steps + STEPS_W'(1);
      if (r_state == CMD)       r_gap <= '0;
      else if (r_state == WAIT) r_gap <= r_gap + GAP_W'(1);
    end
  end

  assign bus.up   = r_up;
  assign bus.down = r_down;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err  = r_err;

endmodule

// File: tb/tb_updown_cmd_gen.sv
// Bench for updown_cmd_gen: a move-level model schedules the expected output
// timeline for every accepted start; a per-cycle compare checks the DUTs against it.
module tb_updown_cmd_gen;

  localparam int W   = 4;
  localparam int GAP = 1;
  localparam int P   = 2 + GAP;  // cycles per step
  localparam int NC  = 2048;     // timeline length in cycles

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  updown_cmd_gen_if #(.WIDTH(W)) bus0 ();
  updown_cmd_gen_if #(.WIDTH(W)) bus1 ();

  // Behavioural counter on instance 0; instance 1 sees a detached counter stuck at 0.
  logic [W-1:0] cnt;
  logic         load;
  logic [W-1:0] load_val;
  always @(posedge clk or negedge rstn) begin
    if (!rstn)          cnt <= '0;
    else if (load)      cnt <= load_val;
    else if (bus0.up)   cnt <= cnt + 1'b1;
    else if (bus0.down) cnt <= cnt - 1'b1;
  end
  assign bus0.count = cnt;
  assign bus1.count = '0;

  updown_cmd_gen #(.WIDTH(W), .STEP_GAP(GAP), .MAX_STEPS(16)) u_dut0 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus0)
  );

  updown_cmd_gen #(.WIDTH(W), .STEP_GAP(GAP), .MAX_STEPS(4)) u_dut1 (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: expected {up,down,busy,done,err} per cycle ----------------
  bit [4:0] exp_o [2][NC];
  int       cyc = 0;

  function automatic bit model_idle(input int inst, input int c);
    if (c < 0 || c >= NC) return 1'b1;
    return exp_o[inst][c][2:0] == 3'b000;
  endfunction

  task automatic clear_from(input int inst, input int c);
    for (int i = (c < 0 ? 0 : c); i < NC; i++) exp_o[inst][i] = '0;
  endtask

  task automatic set_bit(input int inst, input int c, input int b);
    if (c >= 0 && c < NC) exp_o[inst][c][b] = 1'b1;
  endtask

  // Plan a whole move accepted at edge e0 from count c towards target t.
  task automatic plan(input int inst, input int e0, input int c, input int t);
    int  n, d, maxs, pulses, fin;
    bit  go_up;
    maxs = (inst == 0) ? 16 : 4;
`ifdef SHORTEST_PATH_EN
    d = (t - c) & ((1 << W) - 1);
    if (d <= (1 << (W - 1))) begin go_up = 1'b1; n = d; end
    else                     begin go_up = 1'b0; n = (1 << W) - d; end
`else
    if (t > c) begin go_up = 1'b1; n = t - c; end
    else       begin go_up = 1'b0; n = c - t; end
`endif
    if (inst == 1 && n != 0) n = maxs + 1;  // detached counter never arrives
    pulses = (n > maxs) ? maxs : n;
    fin    = e0 + pulses * P;
    for (int e = e0; e <= fin; e++) set_bit(inst, e, 2);
    for (int k = 0; k < pulses; k++) set_bit(inst, e0 + 1 + k * P, go_up ? 4 : 3);
    set_bit(inst, fin + 1, (n > maxs) ? 0 : 1);
  endtask

  task automatic model_edge(input int inst, input int e, input logic st, input logic ab,
                            input int c, input int t);
    if (ab)                               clear_from(inst, e);
    else if (st && model_idle(inst, e - 1)) plan(inst, e, c, t);
  endtask

  // Edge-time model update (counter value read before it updates on this edge).
  always @(posedge clk) begin
    int e;
    e = cyc + 1;
    if (!rstn) begin
      clear_from(0, e);
      clear_from(1, e);
    end else begin
      model_edge(0, e, bus0.start, bus0.abort, int'(bus0.count), int'(bus0.target));
      model_edge(1, e, bus1.start, bus1.abort, int'(bus1.count), int'(bus1.target));
    end
    cyc <= e;
  end

  // ---------------- per-cycle compare and pulse statistics ----------------
  int n_up [2], n_dn [2], n_busy [2], n_done [2], n_err [2];
  int b_up [2], b_dn [2], b_busy [2], b_done [2], b_err [2];

  always @(negedge clk) begin
    logic [4:0] act0, act1, e0v, e1v;
    act0 = {bus0.up, bus0.down, bus0.busy, bus0.done, bus0.err};
    act1 = {bus1.up, bus1.down, bus1.busy, bus1.done, bus1.err};
    e0v  = (rstn && cyc < NC) ? exp_o[0][cyc] : 5'b0;
    e1v  = (rstn && cyc < NC) ? exp_o[1][cyc] : 5'b0;
    check("outs_dut0", 32'(act0), 32'(e0v));
    check("outs_dut1", 32'(act1), 32'(e1v));
    n_up[0]   <= n_up[0]   + int'(bus0.up);
    n_dn[0]   <= n_dn[0]   + int'(bus0.down);
    n_busy[0] <= n_busy[0] + int'(bus0.busy);
    n_done[0] <= n_done[0] + int'(bus0.done);
    n_err[0]  <= n_err[0]  + int'(bus0.err);
    n_up[1]   <= n_up[1]   + int'(bus1.up);
    n_dn[1]   <= n_dn[1]   + int'(bus1.down);
    n_busy[1] <= n_busy[1] + int'(bus1.busy);
    n_done[1] <= n_done[1] + int'(bus1.done);
    n_err[1]  <= n_err[1]  + int'(bus1.err);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      n_up[i] = 0; n_dn[i] = 0; n_busy[i] = 0; n_done[i] = 0; n_err[i] = 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic mark();
    for (int i = 0; i < 2; i++) begin
      b_up[i] = n_up[i]; b_dn[i] = n_dn[i]; b_busy[i] = n_busy[i];
      b_done[i] = n_done[i]; b_err[i] = n_err[i];
    end
  endtask

  task automatic start_move(input int inst, input logic [W-1:0] t);
    if (inst == 0) begin bus0.start = 1'b1; bus0.target = t; end
    else           begin bus1.start = 1'b1; bus1.target = t; end
    step(1);
    bus0.start = 1'b0;
    bus1.start = 1'b0;
  endtask

  task automatic load_count(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    step(1);
    load = 1'b0;
  endtask

  task automatic check_move(input string tag, input int inst, input int up_n, input int dn_n,
                            input int done_n, input int err_n);
    check({tag, "_up"},   32'(n_up[inst]   - b_up[inst]),   32'(up_n));
    check({tag, "_down"}, 32'(n_dn[inst]   - b_dn[inst]),   32'(dn_n));
    check({tag, "_done"}, 32'(n_done[inst] - b_done[inst]), 32'(done_n));
    check({tag, "_err"},  32'(n_err[inst]  - b_err[inst]),  32'(err_n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.start = 1'b0; bus0.abort = 1'b0; bus0.target = '0;
    bus1.start = 1'b0; bus1.abort = 1'b0; bus1.target = '0;
    load = 1'b0; load_val = '0;

    // 1. reset values, then 0 -> 5
    step(3);
    check("rst_outs", 32'({bus0.up, bus0.down, bus0.busy, bus0.done, bus0.err}), 32'(0));
    rstn = 1'b1;
    step(2);
    mark();
    start_move(0, 4'd5);
    step(25);
    check_move("t1", 0, 5, 0, 1, 0);
    check("t1_count", 32'(cnt), 32'(5));

    // 2. 5 -> 2, downward
    mark();
    start_move(0, 4'd2);
    step(20);
    check_move("t2", 0, 0, 3, 1, 0);
    check("t2_count", 32'(cnt), 32'(2));

    // 3. 14 -> 1, direction depends on the build option
    load_count(4'd14);
    mark();
    start_move(0, 4'd1);
    step(50);
`ifdef SHORTEST_PATH_EN
    check_move("t3", 0, 3, 0, 1, 0);
`else
    check_move("t3", 0, 0, 13, 1, 0);
`endif
    check("t3_count", 32'(cnt), 32'(1));

    // 4. already at target
    load_count(4'd9);
    mark();
    start_move(0, 4'd9);
    step(6);
    check_move("t4", 0, 0, 0, 1, 0);
    check("t4_busy_cycles", 32'(n_busy[0] - b_busy[0]), 32'(1));

    // 5. detached counter, MAX_STEPS=4
    mark();
    start_move(1, 4'd3);
    step(20);
    check_move("t5", 1, 4, 0, 0, 1);

    // 6a. start while busy is ignored: 9 -> 14
    mark();
    start_move(0, 4'd14);
    step(2);
    start_move(0, 4'd0);
    step(20);
    check_move("t6a", 0, 5, 0, 1, 0);
    check("t6a_count", 32'(cnt), 32'(14));

    // 6b. abort after the 2nd pulse of 14 -> 10
    mark();
    start_move(0, 4'd10);
    step(4);
    bus0.abort = 1'b1;
    step(1);
    bus0.abort = 1'b0;
    step(15);
    check_move("t6b", 0, 0, 2, 0, 0);
    check("t6b_count", 32'(cnt), 32'(12));
    check("t6b_busy", 32'(bus0.busy), 32'(0));

    // 6c. reset during CMD drops up immediately
    start_move(0, 4'd13);
    step(1);
    check("t6c_up_before_rst", 32'(bus0.up), 32'(1));
    #1 rstn = 1'b0;
    #1 check("t6c_up_at_rst", 32'(bus0.up), 32'(0));
    check("t6c_busy_at_rst", 32'(bus0.busy), 32'(0));
    step(2);
    rstn = 1'b1;
    step(2);
    mark();
    start_move(0, 4'd2);
    step(12);
    check_move("t6c_recover", 0, 2, 0, 1, 0);
    check("t6c_count", 32'(cnt), 32'(2));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
